// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package FetchPackage;

    typedef enum logic [1:0] {
        REQUEST   = 2'd0,
        WAIT_DATA = 2'd1,
        DISCARD   = 2'd2
    } FetchStates;

    localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(INSTRUCTION_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: two-entry in-order FIFO of {pc, data} pairs.
// Entry 0 is always the head, so the consumer sees it straight from a register.
module fetch_buffer
    import FetchPackage::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t entry_in,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t entry0_r;
    fetch_entry_t entry1_r;
    logic [1:0]   count_r;

    // Storage and occupancy; a flush only drops the count, stale data is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_r <= 64'd0;
            entry1_r <= 64'd0;
            count_r  <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_r <= entry_in;
                    end else begin
                        entry1_r <= entry_in;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    entry0_r <= entry1_r;
                    count_r  <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        entry0_r <= entry1_r;
                        entry1_r <= entry_in;
                    end else begin
                        entry0_r <= entry_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Head and status flags come straight from registers.
    always_comb begin
        head  = entry0_r;
        full  = (count_r == 2'd2);
        empty = (count_r == 2'd0);
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch engine feeding a 2-entry buffer.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the outputs when the buffer is empty.
module instruction_fetch
    import FetchPackage::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BUFFER_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        memReadRequest,
    output logic [31:0] memAddress,
    input  logic        memReady,
    input  logic        memReadValid,
    input  logic [31:0] memReadData,
    output logic [31:0] instructionData,
    output logic [31:0] instructionPC,
    output logic        instructionValid,
    input  logic        instructionReady,
    input  logic        redirect,
    input  logic [31:0] redirectAddress
);

    FetchStates   state_r;
    FetchStates   state_next_s;
    logic [31:0]  fetch_pc_r;
    logic [31:0]  pending_pc_r;
    fetch_entry_t head_s;
    fetch_entry_t entry_in_s;
    logic         full_s;
    logic         empty_s;
    logic [31:0]  occupancy_s;
    logic [31:0]  outstanding_s;
    logic         accept_s;
    logic         response_s;
    logic         push_s;
    logic         pop_s;
    logic         buf_valid_s;

    fetch_buffer u_buffer (
        .clk      (clk),
        .rst_n    (rst),
        .push     (push_s),
        .pop      (pop_s),
        .flush    (redirect),
        .entry_in (entry_in_s),
        .head     (head_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // Request gating, handshakes and output selection.
    always_comb begin
        occupancy_s    = full_s ? 32'd2 : (empty_s ? 32'd0 : 32'd1);
        outstanding_s  = (state_r == REQUEST) ? 32'd0 : 32'd1;
        // rst gates the request so it drops immediately when reset asserts.
        memReadRequest = rst && (state_r == REQUEST) && !redirect &&
                         ((occupancy_s + outstanding_s) < 32'(BUFFER_DEPTH));
        memAddress     = fetch_pc_r;
        accept_s       = memReadRequest && memReady;
        response_s     = memReadValid && (state_r == WAIT_DATA) && !redirect;
        entry_in_s.pc   = pending_pc_r;
        entry_in_s.data = memReadData;
        buf_valid_s    = !empty_s;
        pop_s          = buf_valid_s && instructionReady && !redirect;
`ifdef FETCH_BYPASS_EN
        if (empty_s && response_s) begin
            instructionValid = 1'b1;
            instructionData  = memReadData;
            instructionPC    = pending_pc_r;
            push_s           = !instructionReady;
        end else begin
            instructionValid = buf_valid_s;
            instructionData  = head_s.data;
            instructionPC    = head_s.pc;
            push_s           = response_s;
        end
`else
        instructionValid = buf_valid_s;
        instructionData  = head_s.data;
        instructionPC    = head_s.pc;
        push_s           = response_s;
`endif
    end

    // Fetch FSM next-state; a redirect with data in flight must drain that response.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            REQUEST: begin
                if (accept_s) state_next_s = WAIT_DATA;
                else          state_next_s = REQUEST;
            end
            WAIT_DATA: begin
                if (memReadValid)  state_next_s = REQUEST;
                else if (redirect) state_next_s = DISCARD;
                else               state_next_s = WAIT_DATA;
            end
            DISCARD: begin
                if (memReadValid) state_next_s = DISCARD == DISCARD ? REQUEST : REQUEST;
                else              state_next_s = DISCARD;
            end
            default: state_next_s = REQUEST;
        endcase
    end

    // State, fetch PC and the PC of the request currently in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= REQUEST;
            fetch_pc_r   <= RESET_VECTOR;
            pending_pc_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (redirect) begin
                fetch_pc_r <= word_align(redirectAddress);
            end else if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + INSTRUCTION_BYTES;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            if (accept_s) begin
                pending_pc_r <= fetch_pc_r;
            end else begin
                pending_pc_r <= pending_pc_r;
            end
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, meaning: first fetch address after reset.
REQ-002 Parameter BUFFER_DEPTH, default 2, meaning: instruction buffer entries; only 2 is supported.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 memReadRequest  output  1  instruction memory read request.
REQ-006 memAddress  output  32  word-aligned read address, valid while memReadRequest=1.
REQ-007 memReady  input  1  memory accepts the request this cycle.
REQ-008 memReadValid  input  1  read data returned this cycle.
REQ-009 memReadData  input  32  returned instruction word.
REQ-010 instructionData  output  32  instruction word to the Control decoder.
REQ-011 instructionPC  output  32  address of instructionData.
REQ-012 instructionValid  output  1  instructionData/instructionPC valid.
REQ-013 instructionReady  input  1  consumer accepts the instruction this cycle.
REQ-014 redirect  input  1  taken branch/jump/exception; flush and refetch.
REQ-015 redirectAddress  input  32  new fetch address; bits [1:0] ignored (forced 0).

Function
REQ-016 Request handshake: request accepted on cycle with memReadRequest=1 and memReady=1; memAddress SHALL stay stable until then.
REQ-017 At most one request outstanding; response arrives >=1 cycle after acceptance, in order.
REQ-018 memReadRequest SHALL assert only if buffer occupancy plus outstanding count < 2.
REQ-019 fetchPC SHALL advance by 4 on each accepted request; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 FSM states: REQUEST (drive request), WAIT_DATA (one outstanding), DISCARD (outstanding response to drop); REQUEST->WAIT_DATA on accept; WAIT_DATA->REQUEST on memReadValid; WAIT_DATA->DISCARD on redirect without memReadValid; DISCARD->REQUEST on memReadValid (data dropped).
REQ-021 Output handshake: buffer head popped on instructionValid=1 and instructionReady=1; instructionData/PC stable while valid and not ready.
REQ-022 Each response SHALL be pushed with the PC of its request; push and pop in the same cycle SHALL both occur.
REQ-023 Redirect: buffer emptied next cycle, fetchPC=redirectAddress&~3, any response that cycle dropped, instructionValid=0 next cycle; no request accepted in the redirect cycle (memReadRequest masked).
REQ-024 Redirect while in DISCARD: fetchPC updated, state stays DISCARD.
REQ-025 Latency without bypass: memReadValid at cycle N -> instructionValid at N+1 (buffer empty).
REQ-026 memReadValid while buffer full is a protocol violation, prevented by REQ-018.

Reset
REQ-027 On rst=0, asynchronously: memReadRequest=0, instructionValid=0, instructionData=0, instructionPC=0, buffer empty, state=REQUEST, fetchPC=RESET_VECTOR.
REQ-028 First request SHALL assert in the first cycle after rst deasserts; reset mid-transaction abandons outstanding response.

Configuration
REQ-029 Macro FETCH_BYPASS_EN: defined -> with buffer empty, memReadData/PC drive outputs combinationally with instructionValid in cycle N; entry not stored if accepted that cycle.
REQ-030 Undefined -> all outputs registered from buffer (REQ-025 latency).

Structure
REQ-031 Package FetchPackage holds FetchStates enum (REQUEST, WAIT_DATA, DISCARD) and constant INSTRUCTION_BYTES=4.
REQ-032 Sub-module fetch_buffer: 2-entry FIFO of {pc[31:0], data[31:0]} with push/pop/flush/full/empty.

Verification
REQ-033 Reset, memReady=1, 1-cycle memory, instructionReady=1 -> addresses 0,4,8 issued; instructions emitted in order with PCs 0,4,8.
REQ-034 instructionReady=0 for 10 cycles -> exactly 2 instructions buffered, memReadRequest=0, outputs stable at PC 0.
REQ-035 Redirect to 32'h0000_0103 while request outstanding -> that response dropped, next memAddress=32'h0000_0100, first output PC 32'h100.
REQ-036 redirectAddress=32'hFFFF_FFFC -> fetch addresses FFFF_FFFC then 0000_0000.
REQ-037 memReady low 5 cycles -> memAddress held; rst=0 mid-wait -> outputs cleared immediately, restart at RESET_VECTOR.
REQ-038 With FETCH_BYPASS_EN, empty buffer, memReadValid at cycle N -> instructionValid at cycle N; without, at N+1.
